move_conditioner: RTL

Input conditioner that sits directly upstream of `move_cursor`, between the raw direction buttons and its `move[3:0]` input. Each of the four direction lines is synchronised and debounced, then converted into single-cycle step pulses. A held button auto-repeats after an initial delay, so `move_cursor` sees clean, rate-controlled steps instead of bouncing levels. All four channels are identical and fully independent.

---
 rtl/move_conditioner.sv | 122 ++++++++++++
 1 files changed

// File: rtl/move_conditioner.sv
// Direction-button conditioner: per channel 2-flop sync, debounce, then a
// press/auto-repeat FSM that emits single-cycle step pulses for move_cursor.
module move_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd250000,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_RATE     = 32'd6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] move_raw,
  output logic [3:0] move_out,
  output logic [3:0] move_held
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 32;

  localparam logic [CW-1:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = 32'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [1:0]    sync_q, sync_d;
    logic          held_q, held_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    state_e        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          out_q, out_d;
    logic          rise;

    always_comb sync_d = {sync_q[0], move_raw[ch]};

    // Debounce: level follows sync only after DEBOUNCE_CYCLES of sustained difference.
    always_comb begin
      held_d   = held_q;
      db_cnt_d = '0;
      if (sync_q[1] != held_q) begin
        if (db_cnt_q == DB_LAST) begin
          held_d = sync_q[1];
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
    end

    // Pulse coincides with the debounced rise, so the FSM looks at held_d for it.
    assign rise = held_d & ~held_q;

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      out_d   = 1'b0;
      if (rise) begin
        out_d   = 1'b1;
        timer_d = '0;
        state_d = ST_DELAY;
      end else begin
        case (state_q)
          ST_IDLE: begin
            timer_d = '0;
          end
          ST_DELAY: begin
            if (!held_q) begin
              state_d = ST_IDLE;
              timer_d = '0;
            end else if (timer_q == RD_LAST) begin
              // A release landing on the same cycle suppresses the pulse.
              out_d   = held_d;
              timer_d = '0;
              state_d = ST_REPEAT;
            end else begin
              timer_d = timer_q + 32'd1;
            end
          end
          ST_REPEAT: begin
            if (!held_q) begin
              state_d = ST_IDLE;
              timer_d = '0;
            end else if (timer_q == RR_LAST) begin
              out_d   = held_d;
              timer_d = '0;
            end else begin
              timer_d = timer_q + 32'd1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q   <= '0;
        held_q   <= 1'b0;
        db_cnt_q <= '0;
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        out_q    <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        held_q   <= held_d;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        timer_q  <= timer_d;
        out_q    <= out_d;
      end
    end

    assign move_out[ch]  = out_q;
    assign move_held[ch] = held_q;
  end

endmodule
